// File: rtl/mm2fifo_adv.sv
// -----------------------------------------------------------------------------
// mm2fifo_adv
//
// AXI4 read master (memory-mapped to stream) that fetches one image frame per
// start condition and pushes every data beat into a write-side FIFO. A frame is
// img_height lines. Line n starts at base_addr + n*img_stride. Each line is
// img_width/C_ADATA_PIXELS beats of C_M_AXI_DATA_WIDTH bits. Lines are fetched
// as INCR bursts of at most C_M_AXI_BURST_LEN beats. A burst never crosses a
// line boundary, and only one burst is outstanding at a time.
//
// Optional feature macro: MM2FIFO_USER_EN
//   When defined, the sof/eol sideband outputs are added. Both are qualified
//   by wr_en.
//
// Ports
//   M_AXI_ACLK / M_AXI_ARESETN    clock, asynchronous active-low reset
//   soft_resetn                   0 aborts the frame at the next burst boundary
//   resetting                     high while a hard or soft reset is draining
//   img_width/img_height          frame geometry (pixels per line, lines)
//   img_stride                    line pitch in bytes
//   base_addr                     frame start address, captured at frame start
//   frame_pulse                   one-cycle pulse after the last beat of a frame
//   dout / wr_en                  FIFO write data and write strobe
//   wr_data_count                 FIFO fill level, used for space reservation
//   sof / eol                     (MM2FIFO_USER_EN) first beat of frame, last
//                                 beat of line
//   M_AXI_AR* / M_AXI_R*          AXI4 read address and read data channels
//   read_resp_error               RVALID with an error response (RRESP[1])
//   col_idx / row_idx             count-down of pixels left in the line and
//                                 lines left in the frame
// -----------------------------------------------------------------------------
module mm2fifo_adv #(
    parameter int C_DATACOUNT_BITS   = 12,
    parameter int C_FIFO_DEPTH       = 2048,
    parameter int C_M_AXI_BURST_LEN  = 16,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_IMG_WBITS        = 12,
    parameter int C_IMG_HBITS        = 12,
    parameter int C_ADATA_PIXELS     = 4
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESETN,
    input  logic                          soft_resetn,
    output logic                          resetting,
    input  logic [C_IMG_WBITS-1:0]        img_width,
    input  logic [C_IMG_HBITS-1:0]        img_height,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] img_stride,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] base_addr,
    output logic                          frame_pulse,
    output logic [C_M_AXI_DATA_WIDTH-1:0] dout,
    output logic                          wr_en,
    input  logic [C_DATACOUNT_BITS-1:0]   wr_data_count,
`ifdef MM2FIFO_USER_EN
    output logic                          sof,
    output logic                          eol,
`endif
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [7:0]                    M_AXI_ARLEN,
    output logic [2:0]                    M_AXI_ARSIZE,
    output logic [1:0]                    M_AXI_ARBURST,
    output logic                          M_AXI_ARLOCK,
    output logic [3:0]                    M_AXI_ARCACHE,
    output logic [2:0]                    M_AXI_ARPROT,
    output logic [3:0]                    M_AXI_ARQOS,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RLAST,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY,
    output logic                          read_resp_error,
    output logic [C_IMG_WBITS-1:0]        col_idx,
    output logic [C_IMG_HBITS-1:0]        row_idx
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOF,
        ST_WAIT_SPACE,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } state_t;

    localparam int BYTES_PER_BEAT = C_M_AXI_DATA_WIDTH / 8;
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] BURST_BYTES =
        C_M_AXI_ADDR_WIDTH'(C_M_AXI_BURST_LEN * BYTES_PER_BEAT);
    localparam logic [C_IMG_WBITS-1:0] PIX_STEP = C_IMG_WBITS'(C_ADATA_PIXELS);
    localparam logic [2:0] AXI_SIZE = 3'($clog2(BYTES_PER_BEAT));

    state_t                          state;
    state_t                          state_next;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   line_addr;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   araddr;
    logic [C_IMG_WBITS-1:0]          width_q;
    logic [7:0]                      arlen_q;
    logic [7:0]                      arlen_calc;
    logic [7:0]                      beat_cnt;
    logic                            first_beat;
    int                              rem_beats;
    int                              burst_beats;
    int                              free_words;
    logic                            space_ok;
    logic                            beat_fire;
    logic                            last_beat;
    logic                            line_end;
    logic                            frame_end;

    // RLAST is deliberately ignored: the burst ends on the internal beat
    // count, so a slave with a misplaced RLAST cannot desynchronise the
    // frame. RRESP[0] only separates OKAY from EXOKAY, which is irrelevant.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, M_AXI_RLAST, M_AXI_RRESP[0]};

    // Size the next burst from what is left of the current line, capped at
    // the maximum burst length. The burst may only be issued once the FIFO
    // has room for the whole burst. That reservation lets RREADY stay high
    // for the entire data phase.
    always_comb begin
        rem_beats   = int'(col_idx / PIX_STEP) + 1;
        burst_beats = (rem_beats > C_M_AXI_BURST_LEN) ? C_M_AXI_BURST_LEN : rem_beats;
        free_words  = C_FIFO_DEPTH - int'(wr_data_count);
        arlen_calc  = 8'(burst_beats - 1);
        space_ok    = (free_words >= burst_beats);
    end

    assign beat_fire = M_AXI_RVALID & M_AXI_RREADY;
    assign last_beat = (beat_cnt == arlen_q);
    assign line_end  = (col_idx == '0);
    assign frame_end = line_end && (row_idx == '0);

    assign M_AXI_ARADDR    = araddr;
    assign M_AXI_ARLEN     = arlen_q;
    assign M_AXI_ARSIZE    = AXI_SIZE;
    assign M_AXI_ARBURST   = 2'b01;
    assign M_AXI_ARLOCK    = 1'b0;
    assign M_AXI_ARCACHE   = 4'b0010;
    assign M_AXI_ARPROT    = 3'b000;
    assign M_AXI_ARQOS     = 4'b0000;
    assign M_AXI_ARVALID   = (state == ST_ADDR);
    assign M_AXI_RREADY    = (state == ST_DATA);

    // Beats that are drained during a soft reset are still accepted on the
    // bus, but they never reach the FIFO.
    assign dout            = M_AXI_RDATA;
    assign wr_en           = beat_fire & ~resetting;
    assign read_resp_error = M_AXI_RVALID & M_AXI_RRESP[1];

`ifdef MM2FIFO_USER_EN
    assign sof = wr_en & first_beat;
    assign eol = wr_en & line_end;
`endif

    // State register.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A soft reset only takes effect at burst boundaries.
    // Once the address handshake is done, the burst is always drained.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if ((img_width != '0) && (img_height != '0) && soft_resetn) begin
                    state_next = ST_SOF;
                end
            end
            ST_SOF: begin
                state_next = ST_WAIT_SPACE;
            end
            ST_WAIT_SPACE: begin
                if (!soft_resetn) begin
                    state_next = ST_IDLE;
                end else if (space_ok) begin
                    state_next = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (M_AXI_ARREADY) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (beat_fire && last_beat) begin
                    if (resetting) begin
                        state_next = ST_IDLE;
                    end else if (frame_end) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_WAIT_SPACE;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath.
    // col_idx counts down in pixels and row_idx counts down in lines, so the
    // end of a line or a frame is a simple compare against zero.
    // araddr always points at the start of the next burst.
    // line_addr holds the start of the current line, and the stride is
    // added to it at each line boundary.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            resetting   <= 1'b1;
            frame_pulse <= 1'b0;
            line_addr   <= '0;
            araddr      <= '0;
            width_q     <= '0;
            col_idx     <= '0;
            row_idx     <= '0;
            arlen_q     <= '0;
            beat_cnt    <= '0;
            first_beat  <= 1'b0;
        end else begin
            frame_pulse <= (state == ST_DATA) && (state_next == ST_DONE);

            if (state == ST_IDLE) begin
                resetting <= 1'b0;
            end else if (!soft_resetn) begin
                resetting <= 1'b1;
            end

            case (state)
                ST_SOF: begin
                    line_addr  <= base_addr;
                    araddr     <= base_addr;
                    width_q    <= img_width;
                    col_idx    <= img_width - PIX_STEP;
                    row_idx    <= img_height - 1'b1;
                    first_beat <= 1'b1;
                end
                ST_WAIT_SPACE: begin
                    if (space_ok) begin
                        arlen_q  <= arlen_calc;
                        beat_cnt <= '0;
                    end
                end
                ST_DATA: begin
                    if (beat_fire) begin
                        first_beat <= 1'b0;
                        beat_cnt   <= beat_cnt + 1'b1;
                        if (line_end) begin
                            col_idx <= width_q - PIX_STEP;
                            if (row_idx != '0) begin
                                row_idx <= row_idx - 1'b1;
                            end
                        end else begin
                            col_idx <= col_idx - PIX_STEP;
                        end
                        if (last_beat) begin
                            if (line_end) begin
                                line_addr <= line_addr + img_stride;
                                araddr    <= line_addr + img_stride;
                            end else begin
                                araddr    <= araddr + BURST_BYTES;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mm2fifo_adv.sv
// -----------------------------------------------------------------------------
// tb_mm2fifo_adv
//
// Bench for mm2fifo_adv. For each frame it pushes the expected AR requests and
// the expected FIFO words onto queues. A behavioural AXI read slave serves the
// bursts from an address-derived memory pattern. A negedge monitor pops the
// queues and compares them with the traffic the DUT produces.
// -----------------------------------------------------------------------------
module tb_mm2fifo_adv;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DCB   = 12;
    localparam int DEPTH = 2048;
    localparam int BL    = 16;
    localparam int WB    = 12;
    localparam int HB    = 12;
    localparam int PIX   = 4;
    localparam int BPB   = DW / 8;

    logic            M_AXI_ACLK = 1'b0;
    logic            M_AXI_ARESETN;
    logic            soft_resetn;
    logic            resetting;
    logic [WB-1:0]   img_width;
    logic [HB-1:0]   img_height;
    logic [AW-1:0]   img_stride;
    logic [AW-1:0]   base_addr;
    logic            frame_pulse;
    logic [DW-1:0]   dout;
    logic            wr_en;
    logic [DCB-1:0]  wr_data_count;
`ifdef MM2FIFO_USER_EN
    logic            sof;
    logic            eol;
`endif
    logic [AW-1:0]   M_AXI_ARADDR;
    logic [7:0]      M_AXI_ARLEN;
    logic [2:0]      M_AXI_ARSIZE;
    logic [1:0]      M_AXI_ARBURST;
    logic            M_AXI_ARLOCK;
    logic [3:0]      M_AXI_ARCACHE;
    logic [2:0]      M_AXI_ARPROT;
    logic [3:0]      M_AXI_ARQOS;
    logic            M_AXI_ARVALID;
    logic            M_AXI_ARREADY;
    logic [DW-1:0]   M_AXI_RDATA;
    logic [1:0]      M_AXI_RRESP;
    logic            M_AXI_RLAST;
    logic            M_AXI_RVALID;
    logic            M_AXI_RREADY;
    logic            read_resp_error;
    logic [WB-1:0]   col_idx;
    logic [HB-1:0]   row_idx;

    always #5 M_AXI_ACLK = ~M_AXI_ACLK;

    mm2fifo_adv #(
        .C_DATACOUNT_BITS  (DCB),
        .C_FIFO_DEPTH      (DEPTH),
        .C_M_AXI_BURST_LEN (BL),
        .C_M_AXI_ADDR_WIDTH(AW),
        .C_M_AXI_DATA_WIDTH(DW),
        .C_IMG_WBITS       (WB),
        .C_IMG_HBITS       (HB),
        .C_ADATA_PIXELS    (PIX)
    ) dut (
        .M_AXI_ACLK     (M_AXI_ACLK),
        .M_AXI_ARESETN  (M_AXI_ARESETN),
        .soft_resetn    (soft_resetn),
        .resetting      (resetting),
        .img_width      (img_width),
        .img_height     (img_height),
        .img_stride     (img_stride),
        .base_addr      (base_addr),
        .frame_pulse    (frame_pulse),
        .dout           (dout),
        .wr_en          (wr_en),
        .wr_data_count  (wr_data_count),
`ifdef MM2FIFO_USER_EN
        .sof            (sof),
        .eol            (eol),
`endif
        .M_AXI_ARADDR   (M_AXI_ARADDR),
        .M_AXI_ARLEN    (M_AXI_ARLEN),
        .M_AXI_ARSIZE   (M_AXI_ARSIZE),
        .M_AXI_ARBURST  (M_AXI_ARBURST),
        .M_AXI_ARLOCK   (M_AXI_ARLOCK),
        .M_AXI_ARCACHE  (M_AXI_ARCACHE),
        .M_AXI_ARPROT   (M_AXI_ARPROT),
        .M_AXI_ARQOS    (M_AXI_ARQOS),
        .M_AXI_ARVALID  (M_AXI_ARVALID),
        .M_AXI_ARREADY  (M_AXI_ARREADY),
        .M_AXI_RDATA    (M_AXI_RDATA),
        .M_AXI_RRESP    (M_AXI_RRESP),
        .M_AXI_RLAST    (M_AXI_RLAST),
        .M_AXI_RVALID   (M_AXI_RVALID),
        .M_AXI_RREADY   (M_AXI_RREADY),
        .read_resp_error(read_resp_error),
        .col_idx        (col_idx),
        .row_idx        (row_idx)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Scoreboard queues, filled by applyStimulus and drained by the monitor.
    logic [AW-1:0] exp_ar_addr_q[$];
    logic [7:0]    exp_ar_len_q[$];
    logic [DW-1:0] exp_data_q[$];
    bit            exp_sof_q[$];
    bit            exp_eol_q[$];

    // Event counters maintained by the monitor.
    int wr_total         = 0;
    int ar_total         = 0;
    int pulse_total      = 0;
    int drained_total    = 0;
    int arvalid_cycles   = 0;
    int resetting_cycles = 0;
    int err_flag_cycles  = 0;

    int snap_wr;
    int snap_ar;
    int snap_pulse;

    // Slave state.
    logic [AW-1:0] sl_addr_q[$];
    logic [7:0]    sl_len_q[$];
    int            sl_beat        = 0;
    int            sl_beats_total = 0;
    bit            r_stall        = 0;
    int            err_on_beat    = -1;
    bit            sl_ar_fire;
    bit            sl_r_fire;
    logic [AW-1:0] sl_ar_addr;
    logic [7:0]    sl_ar_len;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    // Single comparison point: counts the comparison and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Builds the expected burst list and word stream for one frame, then
    // drives the frame geometry so the DUT starts fetching.
    task automatic applyStimulus(input logic [AW-1:0] base, input int w, input int h,
                                 input logic [AW-1:0] stride);
        logic [AW-1:0] line;
        logic [AW-1:0] off;
        int            beats;
        int            len;
        snap_wr    = wr_total;
        snap_ar    = ar_total;
        snap_pulse = pulse_total;
        for (int row = 0; row < h; row++) begin
            line  = base + AW'(row) * stride;
            off   = '0;
            beats = w / PIX;
            while (beats > 0) begin
                len = (beats > BL) ? BL : beats;
                exp_ar_addr_q.push_back(line + off);
                exp_ar_len_q.push_back(8'(len - 1));
                for (int b = 0; b < len; b++) begin
                    exp_data_q.push_back(mem_word(line + off + AW'(b * BPB)));
                    exp_sof_q.push_back((row == 0) && (off == '0) && (b == 0));
                    exp_eol_q.push_back((beats == len) && (b == len - 1));
                end
                off   = off + AW'(BL * BPB);
                beats = beats - len;
            end
        end
        base_addr  = base;
        img_stride = stride;
        img_height = HB'(h);
        img_width  = WB'(w);
    endtask

    // Waits (bounded) for frame_pulse, stops further frames, then checks the
    // per-frame totals and that the scoreboard drained completely.
    task automatic waitFrame(input string tag, input int exp_writes, input int exp_bursts);
        for (int c = 0; c < 4000; c++) begin
            @(negedge M_AXI_ACLK);
            if (frame_pulse) break;
        end
        img_width = '0;
        repeat (4) @(negedge M_AXI_ACLK);
        checkOutput({tag, "_writes"}, 64'(wr_total - snap_wr), 64'(exp_writes));
        checkOutput({tag, "_bursts"}, 64'(ar_total - snap_ar), 64'(exp_bursts));
        checkOutput({tag, "_pulses"}, 64'(pulse_total - snap_pulse), 64'd1);
        checkOutput({tag, "_data_left"}, 64'(exp_data_q.size()), 64'd0);
        checkOutput({tag, "_ar_left"}, 64'(exp_ar_addr_q.size()), 64'd0);
    endtask

    // Behavioural AXI read slave: ARREADY is always high, and bursts are
    // served in order from an address-derived pattern. Handshakes are decided
    // at the negedge, and the bus is updated just after the posedge.
    initial begin
        M_AXI_ARREADY = 1'b1;
        M_AXI_RVALID  = 1'b0;
        M_AXI_RDATA   = '0;
        M_AXI_RRESP   = 2'b00;
        M_AXI_RLAST   = 1'b0;
        forever begin
            @(negedge M_AXI_ACLK);
            sl_ar_fire = M_AXI_ARVALID && M_AXI_ARREADY;
            sl_r_fire  = M_AXI_RVALID && M_AXI_RREADY;
            sl_ar_addr = M_AXI_ARADDR;
            sl_ar_len  = M_AXI_ARLEN;
            @(posedge M_AXI_ACLK);
            #1;
            if (sl_ar_fire) begin
                sl_addr_q.push_back(sl_ar_addr);
                sl_len_q.push_back(sl_ar_len);
            end
            if (sl_r_fire && (sl_addr_q.size() > 0)) begin
                sl_beat++;
                sl_beats_total++;
                if (sl_beat > int'(sl_len_q[0])) begin
                    void'(sl_addr_q.pop_front());
                    void'(sl_len_q.pop_front());
                    sl_beat = 0;
                end
            end
            if ((sl_addr_q.size() > 0) && !r_stall) begin
                M_AXI_RVALID = 1'b1;
                M_AXI_RDATA  = mem_word(sl_addr_q[0] + AW'(sl_beat * BPB));
                M_AXI_RLAST  = (sl_beat == int'(sl_len_q[0]));
                M_AXI_RRESP  = (sl_beats_total == err_on_beat) ? 2'b10 : 2'b00;
            end else begin
                M_AXI_RVALID = 1'b0;
                M_AXI_RLAST  = 1'b0;
                M_AXI_RRESP  = 2'b00;
            end
        end
    end

    // Monitor: compares AR requests and FIFO writes against the scoreboard.
    initial begin
        logic [DW-1:0] exp_word;
        logic [AW-1:0] exp_addr;
        logic [7:0]    exp_len;
        bit            exp_flag_sof;
        bit            exp_flag_eol;
        forever begin
            @(negedge M_AXI_ACLK);
            if (M_AXI_ARESETN) begin
                if (M_AXI_ARVALID)   arvalid_cycles++;
                if (resetting)       resetting_cycles++;
                if (frame_pulse)     pulse_total++;
                if (read_resp_error) err_flag_cycles++;
                if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                    ar_total++;
                    checkOutput("ar_expected", 64'(exp_ar_addr_q.size() > 0), 64'd1);
                    if (exp_ar_addr_q.size() > 0) begin
                        exp_addr = exp_ar_addr_q.pop_front();
                        exp_len  = exp_ar_len_q.pop_front();
                        checkOutput("araddr", 64'(M_AXI_ARADDR), 64'(exp_addr));
                        checkOutput("arlen", 64'(M_AXI_ARLEN), 64'(exp_len));
                    end
                end
                if (M_AXI_RVALID && M_AXI_RRESP[1]) begin
                    checkOutput("read_resp_error", 64'(read_resp_error), 64'd1);
                end
                if (M_AXI_RVALID && M_AXI_RREADY && !wr_en) drained_total++;
                if (wr_en) begin
                    wr_total++;
                    checkOutput("wr_expected", 64'(exp_data_q.size() > 0), 64'd1);
                    if (exp_data_q.size() > 0) begin
                        exp_word     = exp_data_q.pop_front();
                        exp_flag_sof = exp_sof_q.pop_front();
                        exp_flag_eol = exp_eol_q.pop_front();
                        checkOutput("dout", 64'(dout), 64'(exp_word));
`ifdef MM2FIFO_USER_EN
                        checkOutput("sof", 64'(sof), 64'(exp_flag_sof));
                        checkOutput("eol", 64'(eol), 64'(exp_flag_eol));
`endif
                    end
                end
            end
        end
    end

    // Global safety net in case a bounded wait is ever bypassed.
    initial begin
        #(10 * 60000);
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Main sequence.
    initial begin
        int arv0;
        int err0;
        int d0;
        int r0;
        int nw;
        M_AXI_ARESETN = 1'b0;
        soft_resetn   = 1'b1;
        img_width     = '0;
        img_height    = '0;
        img_stride    = '0;
        base_addr     = '0;
        wr_data_count = '0;

        // Reset values.
        repeat (3) @(negedge M_AXI_ACLK);
        checkOutput("rst_resetting", 64'(resetting), 64'd1);
        checkOutput("rst_arvalid", 64'(M_AXI_ARVALID), 64'd0);
        checkOutput("rst_rready", 64'(M_AXI_RREADY), 64'd0);
        checkOutput("rst_wr_en", 64'(wr_en), 64'd0);
        checkOutput("rst_frame_pulse", 64'(frame_pulse), 64'd0);
        checkOutput("rst_col_idx", 64'(col_idx), 64'd0);
        checkOutput("rst_row_idx", 64'(row_idx), 64'd0);
        M_AXI_ARESETN = 1'b1;
        repeat (2) @(negedge M_AXI_ACLK);
        checkOutput("resetting_release", 64'(resetting), 64'd0);

        // 64x4 frame: four full-length bursts, one per line.
        applyStimulus(32'h0000_1000, 64, 4, 32'h0000_0100);
        waitFrame("f64x4", 64, 4);

        // 80-pixel lines: a 16-beat burst followed by a 4-beat tail per line.
        applyStimulus(32'h0000_2000, 80, 3, 32'h0000_0200);
        waitFrame("f80x3", 60, 6);

        // FIFO space reservation: no AR until 16 words are free.
        wr_data_count = DCB'(DEPTH - 8);
        arv0 = arvalid_cycles;
        applyStimulus(32'h0000_3000, 64, 1, 32'h0000_0100);
        repeat (20) @(negedge M_AXI_ACLK);
        checkOutput("bp_free8_no_ar", 64'(arvalid_cycles - arv0), 64'd0);
        wr_data_count = DCB'(DEPTH - 15);
        repeat (10) @(negedge M_AXI_ACLK);
        checkOutput("bp_free15_no_ar", 64'(arvalid_cycles - arv0), 64'd0);
        wr_data_count = DCB'(DEPTH - 16);
        waitFrame("bp", 16, 1);
        wr_data_count = '0;

        // Error response on one beat: flagged that cycle, frame still completes.
        err0 = err_flag_cycles;
        err_on_beat = sl_beats_total + 10;
        applyStimulus(32'h0000_4000, 64, 2, 32'h0000_0100);
        waitFrame("err", 32, 2);
        checkOutput("err_flag_cycles", 64'(err_flag_cycles - err0), 64'd1);
        err_on_beat = -1;

        // Soft reset after the fifth beat of the first burst.
        d0 = drained_total;
        r0 = resetting_cycles;
        nw = 0;
        applyStimulus(32'h0000_5000, 64, 2, 32'h0000_0100);
        for (int c = 0; c < 2000; c++) begin
            @(negedge M_AXI_ACLK);
            if (wr_en) begin
                nw++;
                if (nw == 5) begin
                    r_stall     = 1'b1;
                    soft_resetn = 1'b0;
                    break;
                end
            end
        end
        repeat (3) @(negedge M_AXI_ACLK);
        r_stall = 1'b0;
        repeat (40) @(negedge M_AXI_ACLK);
        checkOutput("sr_writes", 64'(wr_total - snap_wr), 64'd5);
        checkOutput("sr_drained", 64'(drained_total - d0), 64'd11);
        checkOutput("sr_no_pulse", 64'(pulse_total - snap_pulse), 64'd0);
        checkOutput("sr_bursts", 64'(ar_total - snap_ar), 64'd1);
        checkOutput("sr_resetting_seen", 64'((resetting_cycles - r0) > 0), 64'd1);
        checkOutput("sr_resetting_end", 64'(resetting), 64'd0);
        checkOutput("sr_arvalid_held", 64'(M_AXI_ARVALID), 64'd0);
        checkOutput("sr_data_unsent", 64'(exp_data_q.size()), 64'd27);
        exp_ar_addr_q.delete();
        exp_ar_len_q.delete();
        exp_data_q.delete();
        exp_sof_q.delete();
        exp_eol_q.delete();
        img_width   = '0;
        soft_resetn = 1'b1;
        repeat (3) @(negedge M_AXI_ACLK);

        // 32x2 frame after recovery (sof/eol checked per beat when enabled).
        applyStimulus(32'h0000_8000, 32, 2, 32'h0000_0080);
        waitFrame("f32x2", 16, 2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
